// File: rtl/label_unit_pkg.sv
// Shared controller definitions: state codes, opcodes, condition-register bits,
// pointer-register numbers and label-unit fault codes.
// Pure definitions; no logic, no latency, no flow control.
package label_unit_pkg;

   // Controller sequencing states.
   localparam logic [3:0] STATE_IDLE   = 4'h0;
   localparam logic [3:0] STATE_FETCH0 = 4'h1;
   localparam logic [3:0] STATE_FETCH1 = 4'h2;
   localparam logic [3:0] STATE_EXEC   = 4'h3;
   localparam logic [3:0] STATE_HALT   = 4'hF;

   // Opcodes live in instr0[31:24].
   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_JMP   = 8'h01;
   localparam logic [7:0] OP_LBSET = 8'h30;  // 2-word: instr1 carries the label id
   localparam logic [7:0] OP_PLIMM = 8'h31;  // P in [23:18], label id in low bits

   // Condition-register bit positions.
   localparam int BIT_CR_ZERO  = 0;
   localparam int BIT_CR_CARRY = 1;
   localparam int BIT_CR_NEG   = 2;

   // Pointer register number that aliases the program counter.
   localparam logic [5:0] PREG_PC = 6'h3F;

   // Label-unit fault codes.
   typedef enum logic [1:0] {
      FAULT_NONE  = 2'b00,
      FAULT_UNDEF = 2'b01,  // PLIMM of a label never defined
      FAULT_REDEF = 2'b10   // LBSET of a label already defined
   } fault_e;

endpackage

// File: rtl/label_table.sv
// Label address table: 2^LABEL_W flop entries plus valid bits, one write port,
// asynchronous reads (write lands at the clock edge, reads are 0-cycle).
// No backpressure: a write is accepted every cycle wr_en is high.
// Ports: clk/reset; wr_en/wr_id/wr_addr write port with wr_hit (entry already
// valid); rd_id -> rd_addr (and rd_valid when LABEL_FAULT_EN is defined).
module label_table
   import label_unit_pkg::*;
#(
   parameter int LABEL_W = 6,
   parameter int ADDR_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [LABEL_W-1:0] wr_id,
   input  logic [ADDR_W-1:0]  wr_addr,
   output logic               wr_hit,
   input  logic [LABEL_W-1:0] rd_id,
   output logic [ADDR_W-1:0]  rd_addr
`ifdef LABEL_FAULT_EN
   ,
   output logic               rd_valid
`endif
);

   localparam int DEPTH = 1 << LABEL_W;

   logic [ADDR_W-1:0] entry_q [DEPTH];
   logic [ADDR_W-1:0] entry_d [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [DEPTH-1:0]  valid_d;

   always_comb begin
      entry_d = entry_q;
      valid_d = valid_q;
      if (wr_en) begin
         entry_d[wr_id] = wr_addr;
         valid_d[wr_id] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         entry_q <= entry_d;
         valid_q <= valid_d;
      end
   end

   assign rd_addr = entry_q[rd_id];
   assign wr_hit  = valid_q[wr_id];
`ifdef LABEL_FAULT_EN
   assign rd_valid = valid_q[rd_id];
`endif

endmodule

// File: rtl/label_unit.sv
// Label table / jump resolution downstream of the sequencing controller.
// Latency: jump request/target combinational in EXEC (0 cycles); pointer-reg
// write registered, seen 1 cycle after the EXEC edge. No backpressure: observes only.
// Ports: clk, reset (async, active-high); current_state/instr0/instr1/pc from
// the controller; pc_update_req/pc_update_addr back to it; preg_we/preg_sel/
// preg_addr to the register file; label_count; fault/fault_code only when the
// LABEL_FAULT_EN macro is defined.
module label_unit
   import label_unit_pkg::*;
#(
   parameter int LABEL_W = 6,
   parameter int ADDR_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         current_state,
   input  logic [31:0]        instr0,
   input  logic [31:0]        instr1,
   input  logic [ADDR_W-1:0]  pc,
   output logic               pc_update_req,
   output logic [ADDR_W-1:0]  pc_update_addr,
   output logic               preg_we,
   output logic [5:0]         preg_sel,
   output logic [ADDR_W-1:0]  preg_addr,
   output logic [LABEL_W:0]   label_count
`ifdef LABEL_FAULT_EN
   ,
   output logic               fault,
   output logic [1:0]         fault_code
`endif
);

   localparam logic [LABEL_W:0] COUNT_MAX = {1'b1, {LABEL_W{1'b0}}};
   localparam logic [LABEL_W:0] COUNT_ONE = {{LABEL_W{1'b0}}, 1'b1};

   logic               exec;
   logic [7:0]         opcode;
   logic [5:0]         pl_sel;
   logic [LABEL_W-1:0] pl_id;
   logic [LABEL_W-1:0] lb_id;
   logic               is_lbset;
   logic               is_plimm;
   logic               pl_ok;
   logic               wr_hit;
   logic [ADDR_W-1:0]  rd_addr;

   logic               preg_we_q,   preg_we_d;
   logic [5:0]         preg_sel_q,  preg_sel_d;
   logic [ADDR_W-1:0]  preg_addr_q, preg_addr_d;
   logic [LABEL_W:0]   count_q,     count_d;

   // Bits of the instruction words this stage never looks at.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{instr1[31:LABEL_W], instr0[17:LABEL_W]};

   // Reset gates the decode so combinational outputs read 0 while reset is held.
   assign exec     = !reset && (current_state == STATE_EXEC);
   assign opcode   = instr0[31:24];
   assign pl_sel   = instr0[23:18];
   assign pl_id    = instr0[LABEL_W-1:0];
   assign lb_id    = instr1[LABEL_W-1:0];
   assign is_lbset = exec && (opcode == OP_LBSET);
   assign is_plimm = exec && (opcode == OP_PLIMM);

`ifdef LABEL_FAULT_EN
   logic   rd_valid;
   logic   fault_q,      fault_d;
   fault_e fault_code_q, fault_code_d;
   fault_e fault_new;

   assign pl_ok = rd_valid;
`else
   // Undefined labels read back the reset value and resolve normally.
   assign pl_ok = 1'b1;
`endif

   // The LBSET id drives the write port; the PLIMM id drives the read port
   // shared by the jump and the pointer-register write.
   label_table #(
      .LABEL_W (LABEL_W),
      .ADDR_W  (ADDR_W)
   ) u_label_table (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (is_lbset),
      .wr_id   (lb_id),
      .wr_addr (pc),
      .wr_hit  (wr_hit),
      .rd_id   (pl_id),
      .rd_addr (rd_addr)
`ifdef LABEL_FAULT_EN
      ,
      .rd_valid (rd_valid)
`endif
   );

   always_comb begin
      pc_update_req  = is_plimm && pl_ok && (pl_sel == PREG_PC);
      pc_update_addr = pc_update_req ? rd_addr : '0;
   end

   always_comb begin
      preg_we_d   = is_plimm && pl_ok && (pl_sel != PREG_PC);
      preg_sel_d  = preg_sel_q;
      preg_addr_d = preg_addr_q;
      if (preg_we_d) begin
         preg_sel_d  = pl_sel;
         preg_addr_d = rd_addr;
      end
   end

   // Only first definitions count; redefinitions leave the count alone.
   always_comb begin
      count_d = count_q;
      if (is_lbset && !wr_hit && (count_q != COUNT_MAX)) begin
         count_d = count_q + COUNT_ONE;
      end
   end

`ifdef LABEL_FAULT_EN
   always_comb begin
      fault_new = FAULT_NONE;
      if (is_plimm && !rd_valid) begin
         fault_new = FAULT_UNDEF;
      end else if (is_lbset && wr_hit) begin
         fault_new = FAULT_REDEF;
      end
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      // Sticky: only the first fault after reset is recorded.
      if ((fault_new != FAULT_NONE) && !fault_q) begin
         fault_d      = 1'b1;
         fault_code_d = fault_new;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_q      <= 1'b0;
         fault_code_q <= FAULT_NONE;
      end else begin
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
      end
   end

   assign fault      = fault_q;
   assign fault_code = fault_code_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         preg_we_q   <= 1'b0;
         preg_sel_q  <= '0;
         preg_addr_q <= '0;
         count_q     <= '0;
      end else begin
         preg_we_q   <= preg_we_d;
         preg_sel_q  <= preg_sel_d;
         preg_addr_q <= preg_addr_d;
         count_q     <= count_d;
      end
   end

   assign preg_we     = preg_we_q;
   assign preg_sel    = preg_sel_q;
   assign preg_addr   = preg_addr_q;
   assign label_count = count_q;

endmodule

// File: tb/tb_label_unit.sv
// Directed bench for label_unit: a behavioural label table predicts each
// instruction's jump and pointer-write outcome into queues that are popped
// and compared when the DUT produces them.
module tb_label_unit;
   import label_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  current_state;
   logic [31:0] instr0;
   logic [31:0] instr1;
   logic [15:0] pc;
   logic        pc_update_req;
   logic [15:0] pc_update_addr;
   logic        preg_we;
   logic [5:0]  preg_sel;
   logic [15:0] preg_addr;
   logic [6:0]  label_count;
`ifdef LABEL_FAULT_EN
   logic        fault;
   logic [1:0]  fault_code;
`endif

   always #5 clk = ~clk;

   label_unit #(.LABEL_W(6), .ADDR_W(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .current_state  (current_state),
      .instr0         (instr0),
      .instr1         (instr1),
      .pc             (pc),
      .pc_update_req  (pc_update_req),
      .pc_update_addr (pc_update_addr),
      .preg_we        (preg_we),
      .preg_sel       (preg_sel),
      .preg_addr      (preg_addr),
      .label_count    (label_count)
`ifdef LABEL_FAULT_EN
      ,
      .fault          (fault),
      .fault_code     (fault_code)
`endif
   );

   typedef struct {
      logic        req;
      logic [15:0] addr;
   } jexp_t;

   typedef struct {
      logic        we;
      logic [5:0]  sel;
      logic [15:0] addr;
      logic [6:0]  cnt;
      logic        flt;
      logic [1:0]  code;
   } pexp_t;

   jexp_t jq[$];
   pexp_t pq[$];

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state.
   logic [15:0] m_tab   [64];
   logic        m_valid [64];
   int          m_count;
   logic [5:0]  m_sel;
   logic [15:0] m_paddr;
   logic        m_fault;
   logic [1:0]  m_code;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 64; i++) begin
         m_tab[i]   = 16'h0;
         m_valid[i] = 1'b0;
      end
      m_count = 0;
      m_sel   = 6'h0;
      m_paddr = 16'h0;
      m_fault = 1'b0;
      m_code  = 2'b00;
      jq.delete();
      pq.delete();
   endtask

   function automatic logic [31:0] plimm(input logic [5:0] p, input logic [5:0] id);
      return {OP_PLIMM, p, 12'h000, id};
   endfunction

   function automatic logic [31:0] lbset0();
      return {OP_LBSET, 24'h000000};
   endfunction

   // Drive one controller cycle, predict, then compare combinational outputs
   // before the edge and registered outputs after it.
   task automatic step(input string tag, input logic [3:0] st, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [15:0] p);
      jexp_t      je;
      pexp_t      pe;
      logic       ex;
      logic [7:0] op;
      logic [5:0] ps;
      logic [5:0] pid;
      logic [5:0] lid;
      logic       ok;
      logic [1:0] nf;
      @(negedge clk);
      current_state = st;
      instr0 = i0;
      instr1 = i1;
      pc = p;
      ex  = (st == STATE_EXEC);
      op  = i0[31:24];
      ps  = i0[23:18];
      pid = i0[5:0];
      lid = i1[5:0];
`ifdef LABEL_FAULT_EN
      ok = m_valid[pid];
`else
      ok = 1'b1;
`endif
      je.req  = ex && (op == OP_PLIMM) && (ps == 6'h3F) && ok;
      je.addr = je.req ? m_tab[pid] : 16'h0;
      pe.we   = ex && (op == OP_PLIMM) && (ps != 6'h3F) && ok;
      if (pe.we) begin
         m_sel   = ps;
         m_paddr = m_tab[pid];
      end
      nf = 2'b00;
      if (ex && (op == OP_PLIMM) && !m_valid[pid]) nf = 2'b01;
      if (ex && (op == OP_LBSET)) begin
         if (m_valid[lid]) nf = 2'b10;
         else if (m_count < 64) m_count++;
         m_tab[lid]   = p;
         m_valid[lid] = 1'b1;
      end
      if ((nf != 2'b00) && !m_fault) begin
         m_fault = 1'b1;
         m_code  = nf;
      end
      pe.sel  = m_sel;
      pe.addr = m_paddr;
      pe.cnt  = 7'(m_count);
      pe.flt  = m_fault;
      pe.code = m_code;
      jq.push_back(je);
      pq.push_back(pe);

      #2;
      je = jq.pop_front();
      check({tag, "/req"},   {31'h0, pc_update_req}, {31'h0, je.req});
      check({tag, "/jaddr"}, {16'h0, pc_update_addr}, {16'h0, je.addr});

      @(posedge clk);
      #1;
      pe = pq.pop_front();
      check({tag, "/we"},    {31'h0, preg_we},     {31'h0, pe.we});
      check({tag, "/sel"},   {26'h0, preg_sel},    {26'h0, pe.sel});
      check({tag, "/paddr"}, {16'h0, preg_addr},   {16'h0, pe.addr});
      check({tag, "/count"}, {25'h0, label_count}, {25'h0, pe.cnt});
`ifdef LABEL_FAULT_EN
      check({tag, "/fault"}, {31'h0, fault},      {31'h0, pe.flt});
      check({tag, "/fcode"}, {30'h0, fault_code}, {30'h0, pe.code});
`endif
   endtask

   initial begin
      logic [5:0]  rid;
      logic [5:0]  rp;
      logic [15:0] lpc;

      m_reset();
      // Reset held with a jump-shaped PLIMM in EXEC: everything must read 0.
      reset = 1'b1;
      current_state = STATE_EXEC;
      instr0 = plimm(6'h3F, 6'd5);
      instr1 = 32'h0;
      pc = 16'h0;
      #2;
      check("rst/req",   {31'h0, pc_update_req},  32'h0);
      check("rst/jaddr", {16'h0, pc_update_addr}, 32'h0);
      check("rst/we",    {31'h0, preg_we},        32'h0);
      check("rst/sel",   {26'h0, preg_sel},       32'h0);
      check("rst/paddr", {16'h0, preg_addr},      32'h0);
      check("rst/count", {25'h0, label_count},    32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Define label 5, then use it immediately as a jump and as a P-write.
      step("lbset5",    STATE_EXEC,   lbset0(), 32'd5, 16'h0012);
      step("jmp5",      STATE_EXEC,   plimm(6'h3F, 6'd5), 32'h0, 16'h0014);
      step("pw3_5",     STATE_EXEC,   plimm(6'd3, 6'd5),  32'h0, 16'h0016);
      step("fetch0",    STATE_FETCH0, plimm(6'd3, 6'd5),  32'h0, 16'h0016);
      step("fetch1",    STATE_FETCH1, plimm(6'h3F, 6'd5), 32'h0, 16'h0017);
      step("idle",      STATE_IDLE,   plimm(6'd4, 6'd5),  32'h0, 16'h0017);
      // Non-PLIMM opcode with PC-pointer bits set must not jump.
      step("nop3f",     STATE_EXEC,   {OP_NOP, 6'h3F, 12'h0, 6'd5}, 32'h0, 16'h0018);
      // Redefine 5; upper instr1 bits must be ignored.
      step("redef5",    STATE_EXEC,   lbset0(), 32'hFFFF_FFC5, 16'h0040);
      step("pw7_5",     STATE_EXEC,   plimm(6'd7, 6'd5),  32'h0, 16'h0042);
      step("jmp5b",     STATE_EXEC,   plimm(6'h3F, 6'd5), 32'h0, 16'h0044);
      // Undefined label 9.
      step("jmp_undef", STATE_EXEC,   plimm(6'h3F, 6'd9), 32'h0, 16'h0046);
      step("pw_undef",  STATE_EXEC,   plimm(6'd2, 6'd9),  32'h0, 16'h0048);

      // Fill every entry; count saturates at 64 with label 5 already counted.
      for (int i = 0; i < 64; i++) begin
         lpc = 16'h0100 + 16'(i * 7);
         step($sformatf("fill%0d", i), STATE_EXEC, lbset0(), 32'(i), lpc);
      end
      step("refill0", STATE_EXEC, lbset0(), 32'd0, 16'hBEEF);

      // Random resolutions against the filled table.
      for (int k = 0; k < 12; k++) begin
         rid = 6'($urandom_range(0, 63));
         rp  = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'($urandom_range(0, 62));
         step($sformatf("rnd%0d", k), STATE_EXEC, plimm(rp, rid), 32'h0, 16'h0200);
         step($sformatf("rndf%0d", k), STATE_FETCH0, 32'h0, 32'h0, 16'h0201);
      end

      // Reset asserted asynchronously mid-EXEC while preg_we is high.
      step("pre_rst", STATE_EXEC, plimm(6'd6, 6'd1), 32'h0, 16'h0300);
      current_state = STATE_EXEC;
      instr0 = plimm(6'h3F, 6'd1);
      #2;
      reset = 1'b1;
      m_reset();
      #1;
      check("mrst/req",   {31'h0, pc_update_req},  32'h0);
      check("mrst/jaddr", {16'h0, pc_update_addr}, 32'h0);
      check("mrst/we",    {31'h0, preg_we},        32'h0);
      check("mrst/sel",   {26'h0, preg_sel},       32'h0);
      check("mrst/paddr", {16'h0, preg_addr},      32'h0);
      check("mrst/count", {25'h0, label_count},    32'h0);
`ifdef LABEL_FAULT_EN
      check("mrst/fault", {31'h0, fault},      32'h0);
      check("mrst/fcode", {30'h0, fault_code}, 32'h0);
`endif
      @(negedge clk);
      reset = 1'b0;

      // Table was cleared: label 1 resolves to the reset value again.
      step("post_jmp1", STATE_EXEC, plimm(6'h3F, 6'd1), 32'h0, 16'h0000);
      step("post_lb1",  STATE_EXEC, lbset0(), 32'd1, 16'h0077);
      step("post_pw1",  STATE_EXEC, plimm(6'd9, 6'd1), 32'h0, 16'h0079);
      step("post_idle", STATE_IDLE, 32'h0, 32'h0, 16'h0079);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
